// File: rtl/store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer_pkg
// Description : Shared constants and types for the store buffer slice.
//               Holds the default buffer depth, the chip/write enable levels,
//               the all-zero bus word and the RAM port operation encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package store_buffer_pkg;

    // Buffer geometry
    localparam int c_STORE_BUF_DEPTH      = 4;
    localparam int c_STORE_BUF_DEPTH_LOG2 = 2;

    // Bus/enable levels shared with the rest of the datapath
    localparam logic        c_CHIP_ENABLE   = 1'b1;
    localparam logic        c_CHIP_DISABLE  = 1'b0;
    localparam logic        c_WRITE_ENABLE  = 1'b1;
    localparam logic        c_WRITE_DISABLE = 1'b0;
    localparam logic [31:0] c_ZERO_WORD     = 32'h0000_0000;
    localparam logic [3:0]  c_SEL_ALL       = 4'hF;

    // What the single RAM port does in a given cycle
    typedef enum logic [1:0] {
        PORT_IDLE  = 2'd0,
        PORT_LOAD  = 2'd1,
        PORT_DRAIN = 2'd2
    } port_op_t;

endpackage
`default_nettype wire

// File: rtl/store_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer_fifo
// Description : Entry storage for the store buffer. Circular array of
//               {word address, byte select, data} with read/write pointers
//               and an occupancy count, plus a per-entry word-match vector
//               that flags every occupied entry whose word address equals
//               the probe word.
// Ports       : clk, rst           - clock, async active-high reset
//               i_push / i_push_*  - enqueue one entry at the clock edge
//               i_pop              - dequeue the head entry at the clock edge
//               i_match_word       - word address to compare against entries
//               o_head_*           - contents of the oldest entry
//               o_match            - per-entry hit flags (occupied entries only)
//               o_empty / o_full   - count==0 / count==DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer_fifo #(
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int WORD_W = ADDR_W - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [WORD_W-1:0] i_push_word,
    input  logic [3:0]        i_push_sel,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    input  logic [WORD_W-1:0] i_match_word,
    output logic [WORD_W-1:0] o_head_word,
    output logic [3:0]        o_head_sel,
    output logic [DATA_W-1:0] o_head_data,
    output logic [DEPTH-1:0]  o_match,
    output logic              o_empty,
    output logic              o_full
);

    logic [WORD_W-1:0] r_word [DEPTH];
    logic [3:0]        r_sel  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Entry contents need no reset: occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_word[r_wr_ptr] <= i_push_word;
            r_sel[r_wr_ptr]  <= i_push_sel;
            r_data[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_word = r_word[r_rd_ptr];
    assign o_head_sel  = r_sel[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];

    // An entry is occupied when its distance from the read pointer
    // (modulo DEPTH) is below the count; only occupied entries may hit.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        localparam logic [PTR_W-1:0] c_IDX = PTR_W'(gi);
        logic [PTR_W-1:0] w_off;
        assign w_off       = c_IDX - r_rd_ptr;
        assign o_match[gi] = ({1'b0, w_off} < r_count) && (r_word[gi] == i_match_word);
    end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Posted-write buffer between the MEM stage and the data RAM
//               port. Stores are queued and retire in order whenever the
//               port is not used by a load. Loads take the port first; a load
//               to a word with a queued store stalls until it has drained.
// Ports       : clk, rst               - clock, async active-high reset
//               req_*                  - MEM stage access (valid/we/addr/sel/data)
//               stall_req              - hold MEM request (full or load hit)
//               ld_data                - load result, same cycle as issue
//               ram_*                  - single RAM port (rdata combinational)
//               sb_empty / sb_full     - buffer status
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = c_STORE_BUF_DEPTH,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_sel,
    input  logic [DATA_W-1:0] req_data,
    output logic              stall_req,
    output logic [DATA_W-1:0] ld_data,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_sel,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              sb_empty,
    output logic              sb_full
);

    localparam int                WORD_W = ADDR_W - 2;
    localparam logic [DATA_W-1:0] c_ZERO = DATA_W'(c_ZERO_WORD);

    logic [WORD_W-1:0] w_head_word;
    logic [3:0]        w_head_sel;
    logic [DATA_W-1:0] w_head_data;
    logic [DEPTH-1:0]  w_match;
    logic              w_empty;
    logic              w_full;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_hit;
    logic              w_push;
    logic              w_pop;
    port_op_t          w_op;

    store_buffer_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_word  (req_addr[ADDR_W-1:2]),
        .i_push_sel   (req_sel),
        .i_push_data  (req_data),
        .i_pop        (w_pop),
        .i_match_word (req_addr[ADDR_W-1:2]),
        .o_head_word  (w_head_word),
        .o_head_sel   (w_head_sel),
        .o_head_data  (w_head_data),
        .o_match      (w_match),
        .o_empty      (w_empty),
        .o_full       (w_full)
    );

    // Requests are masked while reset is high so the RAM port and the
    // pipeline see a quiet interface for the whole reset window.
    assign w_is_load  = ~rst & req_valid & ~req_we;
    assign w_is_store = ~rst & req_valid & req_we;
    assign w_hit      = |w_match;

    // Full-stall uses the registered count only, even if a pop frees a
    // slot in this same cycle.
    assign w_push = w_is_store & ~w_full;

    always_comb begin
        w_op = PORT_IDLE;
        if (w_is_load && !w_hit) begin
            w_op = PORT_LOAD;
        end else if (!rst && !w_empty) begin
            w_op = PORT_DRAIN;
        end
    end

    assign w_pop     = (w_op == PORT_DRAIN);
    assign stall_req = (w_is_store & w_full) | (w_is_load & w_hit);
    assign sb_empty  = w_empty;
    assign sb_full   = w_full;

    always_comb begin
        ram_ce    = c_CHIP_DISABLE;
        ram_we    = c_WRITE_DISABLE;
        ram_addr  = '0;
        ram_sel   = '0;
        ram_wdata = c_ZERO;
        ld_data   = c_ZERO;
        case (w_op)
            PORT_LOAD: begin
                ram_ce   = c_CHIP_ENABLE;
                ram_addr = req_addr;
                ram_sel  = c_SEL_ALL;
                ld_data  = ram_rdata;
            end
            PORT_DRAIN: begin
                ram_ce    = c_CHIP_ENABLE;
                ram_we    = c_WRITE_ENABLE;
                ram_addr  = {w_head_word, 2'b00};
                ram_sel   = w_head_sel;
                ram_wdata = w_head_data;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Self-checking bench for store_buffer. A queue-based model of
//               the buffer plus a reference memory predict every RAM port
//               output, stall and load result each cycle; a behavioural RAM
//               driven by the DUT's own port supplies read data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_sel;
    logic [DATA_W-1:0] req_data;
    logic              stall_req;
    logic [DATA_W-1:0] ld_data;
    logic              ram_ce;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_sel;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              sb_empty;
    logic              sb_full;

    always #5 clk = ~clk;

    store_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_sel   (req_sel),
        .req_data  (req_data),
        .stall_req (stall_req),
        .ld_data   (ld_data),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_sel   (ram_sel),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .sb_empty  (sb_empty),
        .sb_full   (sb_full)
    );

    // Behavioural RAM: 256 words, combinational read, byte-lane writes.
    logic [31:0] mem [0:255];
    assign ram_rdata = mem[ram_addr[9:2]];
    always @(posedge clk) begin
        if (ram_ce && ram_we) begin
            for (int l = 0; l < 4; l++) begin
                if (ram_sel[l]) mem[ram_addr[9:2]][8*l +: 8] <= ram_wdata[8*l +: 8];
            end
        end
    end

    // Reference model: pending stores in program order + expected memory.
    typedef struct {
        logic [29:0] word;
        logic [3:0]  sel;
        logic [31:0] data;
    } ent_t;
    ent_t        q[$];
    logic [31:0] ref_mem [0:255];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive the request, predict and compare outputs, then let
    // the clock edge happen and advance the model.
    task automatic step(input logic v, input logic we, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d,
                        output logic stalled, output logic [31:0] ld_obs);
        logic        hit, is_ld, is_st, ld_issue, drain, full;
        logic        e_ce, e_we, e_stall;
        logic [31:0] e_addr, e_wdata, e_ld;
        logic [3:0]  e_sel;
        req_valid = v; req_we = we; req_addr = a; req_sel = s; req_data = d;
        #1;
        hit = 1'b0;
        foreach (q[i]) if (q[i].word == a[31:2]) hit = 1'b1;
        is_ld    = v && !we;
        is_st    = v && we;
        ld_issue = is_ld && !hit;
        drain    = !ld_issue && (q.size() != 0);
        full     = (q.size() == DEPTH);
        e_stall  = (is_st && full) || (is_ld && hit);
        e_ce = 1'b0; e_we = 1'b0; e_addr = '0; e_sel = '0; e_wdata = '0; e_ld = '0;
        if (ld_issue) begin
            e_ce = 1'b1; e_addr = a; e_sel = 4'hF; e_ld = ref_mem[a[9:2]];
        end else if (drain) begin
            e_ce = 1'b1; e_we = 1'b1; e_addr = {q[0].word, 2'b00};
            e_sel = q[0].sel; e_wdata = q[0].data;
        end
        chk("stall_req", 32'(stall_req), 32'(e_stall));
        chk("ram_ce",    32'(ram_ce),    32'(e_ce));
        chk("ram_we",    32'(ram_we),    32'(e_we));
        chk("ram_addr",  ram_addr,       e_addr);
        chk("ram_sel",   32'(ram_sel),   32'(e_sel));
        if (!ld_issue) chk("ram_wdata", ram_wdata, e_wdata);
        chk("ld_data",   ld_data,        e_ld);
        chk("sb_empty",  32'(sb_empty),  32'(q.size() == 0));
        chk("sb_full",   32'(sb_full),   32'(full));
        stalled = e_stall;
        ld_obs  = ld_data;
        @(posedge clk);
        if (drain) begin
            for (int l = 0; l < 4; l++) begin
                if (q[0].sel[l]) ref_mem[q[0].word[7:0]][8*l +: 8] = q[0].data[8*l +: 8];
            end
            void'(q.pop_front());
        end
        if (is_st && !full) q.push_back('{word: a[31:2], sel: s, data: d});
        @(negedge clk);
    endtask

    initial begin
        logic        st;
        logic [31:0] ld;
        logic        v, we;
        logic [31:0] a, d;
        logic [3:0]  s;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_sel = '0; req_data = '0;

        // Reset state
        #12;
        chk("rst_stall",  32'(stall_req), 32'h0);
        chk("rst_ce",     32'(ram_ce),    32'h0);
        chk("rst_we",     32'(ram_we),    32'h0);
        chk("rst_addr",   ram_addr,       32'h0);
        chk("rst_sel",    32'(ram_sel),   32'h0);
        chk("rst_wdata",  ram_wdata,      32'h0);
        chk("rst_ld",     ld_data,        32'h0);
        chk("rst_empty",  32'(sb_empty),  32'h1);
        chk("rst_full",   32'(sb_full),   32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Idle, then single store drained on the next cycle
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, st, ld);
        step(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, st, ld);
        chk("store_drain_addr",  ram_addr,  32'h10);
        chk("store_drain_wdata", ram_wdata, 32'hDEADBEEF);
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, st, ld);
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, st, ld);

        // Load hit: stall one cycle while 0x20 drains, then load sees 0xAA
        step(1'b1, 1'b1, 32'h20, 4'b0001, 32'h000000AA, st, ld);
        step(1'b1, 1'b0, 32'h22, 4'h0, 32'h0, st, ld);
        chk("hit_stalled", 32'(st), 32'h1);
        step(1'b1, 1'b0, 32'h22, 4'h0, 32'h0, st, ld);
        chk("hit_ld_byte", 32'(ld[7:0]), 32'hAA);

        // Non-hitting load takes the port ahead of a pending store
        step(1'b1, 1'b1, 32'h30, 4'hF, 32'h11223344, st, ld);
        step(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, st, ld);
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, st, ld);

        // Randomised traffic; a stalled request is held unchanged
        st = 1'b0; v = 1'b0; we = 1'b0; a = '0; s = '0; d = '0;
        for (int n = 0; n < 400; n++) begin
            if (!st) begin
                v  = ($urandom % 8) != 0;
                we = $urandom % 2;
                s  = 4'($urandom_range(1, 15));
                d  = $urandom;
                if (!we && ($urandom % 2)) a = 32'h100 + 32'($urandom % 64);
                else                       a = 32'($urandom % 64);
            end
            step(v, we, a, s, d, st, ld);
        end
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, st, ld);

        // Reset with a drain pending: port quiet at once, store discarded
        step(1'b1, 1'b1, 32'h50, 4'hF, 32'hCAFEF00D, st, ld);
        req_valid = 1'b0;
        #1;
        chk("pre_rst_ce", 32'(ram_ce), 32'h1);
        chk("pre_rst_we", 32'(ram_we), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ce",    32'(ram_ce),   32'h0);
        chk("mid_rst_we",    32'(ram_we),   32'h0);
        chk("mid_rst_addr",  ram_addr,      32'h0);
        chk("mid_rst_empty", 32'(sb_empty), 32'h1);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h44;
        #1;
        chk("mid_rst_ld",    ld_data,        32'h0);
        chk("mid_rst_ldce",  32'(ram_ce),    32'h0);
        chk("mid_rst_stall", 32'(stall_req), 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, st, ld);
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, st, ld);
        step(1'b1, 1'b0, 32'h50, 4'h0, 32'h0, st, ld);
        chk("post_rst_no_write", ld, ref_mem[8'h14]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
